// File: rtl/memory_p4_pkg.sv
// Shared types and constants for the memory stage: FSM encoding, EX/MEM control bundle, defaults.
package memory_p4_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int REG_IDX_W   = 3;
  localparam int TIMEOUT_DEF = 15;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 load;
    logic                 reg_write;
    logic [REG_IDX_W-1:0] rd;
  } exm_ctrl_t;

endpackage

// File: rtl/memory_p4_timer.sv
// Access wait counter (built only with MEMORY_P4_TIMEOUT_EN); timeout_o is combinational
// from the count, which clears whenever the access completes or no access is active.
module memory_p4_timer
  import memory_p4_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic active_i,
  input  logic ready_i,
  output logic timeout_o
);

  logic [7:0] cnt_q, cnt_d;

  assign timeout_o = active_i && (cnt_q == 8'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = '0;
    if (active_i && !ready_i && !timeout_o) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/memory_p4.sv
// MEM pipeline stage: EX/MEM register, ready-handshaked data-memory access, MEM/WB register; 1 cycle
// per instruction, stall held while an access waits on mem_ready. Optional timeout: MEMORY_P4_TIMEOUT_EN.
module memory_p4
  import memory_p4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
`ifdef MEMORY_P4_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ex_valid,
  input  logic                 op_mem_read,
  input  logic                 op_mem_write,
  input  logic                 op_reg_write,
  input  logic                 op_flag_update,
  input  logic [REG_IDX_W-1:0] rd_ex,
  input  logic [WIDTH-1:0]     data_register_wire,
  input  logic [WIDTH-1:0]     ar_ex_forward,
  input  logic [3:0]           cond,
  input  logic                 mem_ready,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WIDTH-1:0]     mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 stall,
  output logic [WIDTH-1:0]     data_register_mem,
  output logic [WIDTH-1:0]     data_for_res_wb,
  output logic [REG_IDX_W-1:0] rd_wb,
  output logic                 reg_write_wb,
  output logic [3:0]           szcv_flags,
  output logic                 mem_err
);

  mem_state_e           state_q;
  exm_ctrl_t            exm_q, exm_d;
  logic [WIDTH-1:0]     exm_alu_q;
  logic                 mem_req_q, mem_we_q;
  logic [WIDTH-1:0]     mem_addr_q, mem_wdata_q;
  logic [WIDTH-1:0]     wb_data_q, wb_data_d;
  logic [REG_IDX_W-1:0] rd_wb_q;
  logic                 reg_write_wb_q;
  logic [3:0]           szcv_q;
  logic                 ex_load, ex_store, ex_mem_op;
  logic                 in_access, timeout;
  logic [WIDTH-1:0]     load_data;

  // A write wins over a read, and a store never writes the register file.
  always_comb begin
    ex_store  = op_mem_write;
    ex_load   = op_mem_read & ~op_mem_write;
    ex_mem_op = ex_valid & (ex_load | ex_store);
    exm_d     = '0;
    exm_d.rd  = rd_ex;
    if (ex_valid) begin
      exm_d.valid     = 1'b1;
      exm_d.load      = ex_load;
      exm_d.reg_write = op_reg_write & ~op_mem_write;
    end
  end

  assign in_access = (state_q == ST_ACCESS);
  assign stall     = in_access & ~(mem_ready | timeout);
  // A forced completion has no valid read data, so a timed-out load returns zero.
  assign load_data = mem_ready ? mem_rdata : '0;

`ifdef MEMORY_P4_TIMEOUT_EN
  logic err_q;

  memory_p4_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .active_i  (in_access),
    .ready_i   (mem_ready),
    .timeout_o (timeout)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   err_q <= 1'b0;
    else if (timeout && !mem_ready) err_q <= 1'b1;
  end

  assign mem_err = err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      exm_q       <= '0;
      exm_alu_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      szcv_q      <= '0;
    end else if (!stall) begin
      exm_q     <= exm_d;
      exm_alu_q <= data_register_wire;
      if (ex_valid && op_flag_update) begin
        szcv_q[FLAG_S] <= cond[FLAG_S];
        szcv_q[FLAG_Z] <= cond[FLAG_Z];
        szcv_q[FLAG_C] <= cond[FLAG_C];
        szcv_q[FLAG_V] <= cond[FLAG_V];
      end
      if (ex_mem_op) begin
        state_q     <= ST_ACCESS;
        mem_req_q   <= 1'b1;
        mem_we_q    <= ex_store;
        mem_addr_q  <= data_register_wire;
        mem_wdata_q <= ar_ex_forward;
      end else begin
        state_q   <= ST_IDLE;
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    wb_data_d = exm_q.load ? load_data : exm_alu_q;
  end

  // Every stalled cycle pushes a bubble into writeback.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_data_q      <= '0;
      rd_wb_q        <= '0;
      reg_write_wb_q <= 1'b0;
    end else if (exm_q.valid && !stall) begin
      wb_data_q      <= wb_data_d;
      rd_wb_q        <= exm_q.rd;
      reg_write_wb_q <= exm_q.reg_write;
    end else begin
      reg_write_wb_q <= 1'b0;
    end
  end

  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign data_register_mem = exm_alu_q;
  assign data_for_res_wb   = wb_data_q;
  assign rd_wb             = rd_wb_q;
  assign reg_write_wb      = reg_write_wb_q;
  assign szcv_flags        = szcv_q;

endmodule

// File: tb/tb_memory_p4.sv
// Self-checking bench for memory_p4: directed scenarios plus a randomized instruction stream
// scored against a transaction-level model of writebacks, memory accesses, flags and stall cycles.
module tb_memory_p4;

  logic        clock;
  logic        reset;
  logic        ex_valid, op_mem_read, op_mem_write, op_reg_write, op_flag_update;
  logic [2:0]  rd_ex;
  logic [15:0] data_register_wire, ar_ex_forward;
  logic [3:0]  cond;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        mem_req, mem_we, stall, reg_write_wb, mem_err;
  logic [15:0] mem_addr, mem_wdata, data_register_mem, data_for_res_wb;
  logic [2:0]  rd_wb;
  logic [3:0]  szcv_flags;

  int n_cmp = 0;
  int n_err = 0;

  memory_p4 dut (
    .clock              (clock),
    .reset              (reset),
    .ex_valid           (ex_valid),
    .op_mem_read        (op_mem_read),
    .op_mem_write       (op_mem_write),
    .op_reg_write       (op_reg_write),
    .op_flag_update     (op_flag_update),
    .rd_ex              (rd_ex),
    .data_register_wire (data_register_wire),
    .ar_ex_forward      (ar_ex_forward),
    .cond               (cond),
    .mem_ready          (mem_ready),
    .mem_rdata          (mem_rdata),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .stall              (stall),
    .data_register_mem  (data_register_mem),
    .data_for_res_wb    (data_for_res_wb),
    .rd_wb              (rd_wb),
    .reg_write_wb       (reg_write_wb),
    .szcv_flags         (szcv_flags),
    .mem_err            (mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] mem_model(input logic [15:0] addr);
    return {addr[7:0], addr[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic rdm, input logic wrm, input logic rw, input logic fu,
                       input logic [2:0] r, input logic [15:0] a, input logic [15:0] s, input logic [3:0] c);
    ex_valid = v; op_mem_read = rdm; op_mem_write = wrm; op_reg_write = rw; op_flag_update = fu;
    rd_ex = r; data_register_wire = a; ar_ex_forward = s; cond = c;
  endtask

  task automatic test_reset();
    logic [75:0] outs;
    reset = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 4'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    outs = {mem_req, mem_we, mem_addr, mem_wdata, stall, data_register_mem, data_for_res_wb,
            rd_wb, reg_write_wb, szcv_flags, mem_err};
    n_cmp++; if (outs !== 76'd0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_alu_op();
    drive(1, 0, 0, 1, 0, 3'd3, 16'h1234, 16'hAAAA, 4'h0);
    @(negedge clock);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall0: got %b expected 0", stall); end
    tick();
    drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 4'h0);
    @(negedge clock);
    n_cmp++; if (data_register_mem !== 16'h1234) begin n_err++; $display("FAIL alu_fwd: got %h expected 1234", data_register_mem); end
    n_cmp++; if (reg_write_wb !== 1'b0) begin n_err++; $display("FAIL alu_wb_early: got %b expected 0", reg_write_wb); end
    tick();
    @(negedge clock);
    n_cmp++; if ({data_for_res_wb, rd_wb, reg_write_wb, stall} !== {16'h1234, 3'd3, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL alu_wb: got data=%h rd=%0d we=%b stall=%b expected 1234/3/1/0", data_for_res_wb, rd_wb, reg_write_wb, stall);
    end
    tick();
    @(negedge clock);
    n_cmp++; if (reg_write_wb !== 1'b0) begin n_err++; $display("FAIL alu_wb_bubble: got %b expected 0", reg_write_wb); end
    tick();
  endtask

  task automatic test_load_wait();
    int nreq = 0, nstall = 0;
    drive(1, 1, 0, 1, 0, 3'd1, 16'h0040, 16'h0000, 4'h0);
    mem_ready = 1'b0;
    tick();
    drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 2);
      mem_rdata = (k == 2) ? 16'hBEEF : 16'h1111;
      @(negedge clock);
      if (mem_req) nreq++;
      if (stall) nstall++;
      if (k == 0) begin
        n_cmp++; if ({mem_addr, mem_we} !== {16'h0040, 1'b0}) begin n_err++; $display("FAIL load_req: got addr=%h we=%b expected 0040/0", mem_addr, mem_we); end
      end
      if (k == 1 || k == 2) begin
        n_cmp++; if (reg_write_wb !== 1'b0) begin n_err++; $display("FAIL load_stall_bubble: got %b expected 0 (k=%0d)", reg_write_wb, k); end
      end
      if (k == 3) begin
        n_cmp++; if ({data_for_res_wb, rd_wb, reg_write_wb} !== {16'hBEEF, 3'd1, 1'b1}) begin
          n_err++; $display("FAIL load_wb: got data=%h rd=%0d we=%b expected BEEF/1/1", data_for_res_wb, rd_wb, reg_write_wb);
        end
      end
      tick();
    end
    mem_ready = 1'b0;
    n_cmp++; if (nreq !== 3) begin n_err++; $display("FAIL load_req_cycles: got %0d expected 3", nreq); end
    n_cmp++; if (nstall !== 2) begin n_err++; $display("FAIL load_stall_cycles: got %0d expected 2", nstall); end
  endtask

  task automatic test_store();
    drive(1, 0, 1, 1, 0, 3'd5, 16'h0010, 16'h00FF, 4'h0);
    tick();
    drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 4'h0);
    mem_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata, stall} !== {1'b1, 1'b1, 16'h0010, 16'h00FF, 1'b0}) begin
      n_err++; $display("FAIL store_req: got req=%b we=%b addr=%h wdata=%h stall=%b expected 1/1/0010/00FF/0", mem_req, mem_we, mem_addr, mem_wdata, stall);
    end
    tick();
    mem_ready = 1'b0;
    @(negedge clock);
    n_cmp++; if ({mem_req, mem_we, reg_write_wb, mem_addr} !== {1'b0, 1'b0, 1'b0, 16'h0010}) begin
      n_err++; $display("FAIL store_after: got req=%b we=%b wb=%b addr=%h expected 0/0/0/0010", mem_req, mem_we, reg_write_wb, mem_addr);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 0, 1, 0, 3'd2, 16'h0100, 16'h0000, 4'h0);
    mem_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if ({mem_req, stall} !== 2'b00) begin n_err++; $display("FAIL idle_ready_ignored: got req=%b stall=%b expected 0/0", mem_req, stall); end
    tick();
    drive(1, 0, 1, 0, 0, 3'd0, 16'h0200, 16'h5A5A, 4'h0);
    mem_rdata = 16'hC0DE;
    @(negedge clock);
    n_cmp++; if ({mem_req, mem_we, mem_addr, stall} !== {1'b1, 1'b0, 16'h0100, 1'b0}) begin
      n_err++; $display("FAIL b2b_load: got req=%b we=%b addr=%h stall=%b expected 1/0/0100/0", mem_req, mem_we, mem_addr, stall);
    end
    tick();
    drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 4'h0);
    @(negedge clock);
    n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata, stall} !== {1'b1, 1'b1, 16'h0200, 16'h5A5A, 1'b0}) begin
      n_err++; $display("FAIL b2b_store: got req=%b we=%b addr=%h wdata=%h stall=%b expected 1/1/0200/5A5A/0", mem_req, mem_we, mem_addr, mem_wdata, stall);
    end
    n_cmp++; if ({data_for_res_wb, rd_wb, reg_write_wb} !== {16'hC0DE, 3'd2, 1'b1}) begin
      n_err++; $display("FAIL b2b_wb: got data=%h rd=%0d we=%b expected C0DE/2/1", data_for_res_wb, rd_wb, reg_write_wb);
    end
    tick();
    mem_ready = 1'b0;
    @(negedge clock);
    n_cmp++; if ({mem_req, reg_write_wb} !== 2'b00) begin n_err++; $display("FAIL b2b_end: got req=%b wb=%b expected 0/0", mem_req, reg_write_wb); end
    tick();
  endtask

  task automatic test_flags();
    drive(1, 0, 0, 0, 1, 3'd0, 16'h0, 16'h0, 4'b0100);
    tick();
    drive(0, 0, 0, 0, 1, 3'd0, 16'h0, 16'h0, 4'b1111);
    @(negedge clock);
    n_cmp++; if (szcv_flags !== 4'b0100) begin n_err++; $display("FAIL flags_update: got %b expected 0100", szcv_flags); end
    tick();
    drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 4'h0);
    @(negedge clock);
    n_cmp++; if (szcv_flags !== 4'b0100) begin n_err++; $display("FAIL flags_bubble: got %b expected 0100", szcv_flags); end
    tick();
  endtask

  task automatic test_random();
    localparam int N = 200;
    logic [15:0] q_wb_data[$], q_acc_addr[$], q_acc_wdata[$];
    logic [2:0]  q_wb_rd[$];
    logic        q_acc_we[$];
    int          q_wait[$];
    logic [3:0]  exp_flags = 4'b0100;  // left there by test_flags
    logic [15:0] last_alu = '0;
    logic        last_valid = 1'b0, loaded = 1'b1, serving = 1'b0, cur_gen = 1'b0;
    int issued = 0, consumed = 0, wait_left = 0, stall_total = 0, exp_stall_total = 0, cyc = 0;
    logic [15:0] d, a, wd;
    logic        we;
    int          w;
    while (cyc < 5000) begin
      if (loaded) begin
        if (issued < N) begin
          int kind = $urandom_range(0, 3);
          drive(($urandom_range(0, 9) != 0), (kind == 1 || kind == 3), (kind == 2 || kind == 3),
                1'($urandom), 1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
          issued++; cur_gen = 1'b1;
        end else begin
          drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 4'h0);
          cur_gen = 1'b0;
        end
      end
      if (mem_req && !serving) begin
        serving = 1'b1;
        if (q_wait.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL rnd_unexpected_access: got req at addr %h expected none", mem_addr);
          wait_left = 0;
        end else wait_left = q_wait.pop_front();
      end
      if (serving) begin
        mem_ready = (wait_left == 0);
        mem_rdata = mem_ready ? mem_model(mem_addr) : 16'($urandom);
      end else begin
        mem_ready = 1'($urandom);
        mem_rdata = 16'($urandom);
      end
      @(negedge clock);
      if (reg_write_wb) begin
        n_cmp++;
        if (q_wb_data.size() == 0) begin
          n_err++; $display("FAIL rnd_wb_extra: got data=%h rd=%0d expected no writeback", data_for_res_wb, rd_wb);
        end else begin
          d = q_wb_data.pop_front();
          if ({data_for_res_wb, rd_wb} !== {d, q_wb_rd[0]}) begin
            n_err++; $display("FAIL rnd_wb: got data=%h rd=%0d expected %h/%0d", data_for_res_wb, rd_wb, d, q_wb_rd[0]);
          end
          void'(q_wb_rd.pop_front());
        end
      end
      if (serving && mem_req && mem_ready) begin
        serving = 1'b0;
        n_cmp++;
        if (q_acc_addr.size() == 0) begin
          n_err++; $display("FAIL rnd_acc_extra: got addr=%h expected no access", mem_addr);
        end else begin
          a = q_acc_addr.pop_front(); we = q_acc_we.pop_front(); wd = q_acc_wdata.pop_front();
          if (mem_addr !== a || mem_we !== we || (we && mem_wdata !== wd)) begin
            n_err++; $display("FAIL rnd_access: got addr=%h we=%b wdata=%h expected %h/%b/%h", mem_addr, mem_we, mem_wdata, a, we, wd);
          end
        end
      end else if (serving) wait_left--;
      if (stall) stall_total++;
      n_cmp++; if (szcv_flags !== exp_flags) begin n_err++; $display("FAIL rnd_flags: got %b expected %b", szcv_flags, exp_flags); end
      if (last_valid) begin
        n_cmp++; if (data_register_mem !== last_alu) begin n_err++; $display("FAIL rnd_fwd: got %h expected %h", data_register_mem, last_alu); end
      end
      loaded = !stall;
      if (loaded) begin
        if (cur_gen) consumed++;
        last_valid = ex_valid; last_alu = data_register_wire;
        if (ex_valid) begin
          if (op_reg_write && !op_mem_write) begin
            q_wb_data.push_back((op_mem_read && !op_mem_write) ? mem_model(data_register_wire) : data_register_wire);
            q_wb_rd.push_back(rd_ex);
          end
          if (op_mem_read || op_mem_write) begin
            w = $urandom_range(0, 3);
            q_wait.push_back(w); exp_stall_total += w;
            q_acc_addr.push_back(data_register_wire); q_acc_we.push_back(op_mem_write);
            q_acc_wdata.push_back(ar_ex_forward);
          end
          if (op_flag_update) exp_flags = cond;
        end
      end
      if (consumed == N && q_wb_data.size() == 0 && q_acc_addr.size() == 0 && !serving) break;
      tick();
      cyc++;
    end
    n_cmp++; if (cyc >= 5000) begin n_err++; $display("FAIL rnd_drain: got %0d cycles expected fewer than 5000", cyc); end
    n_cmp++; if (stall_total !== exp_stall_total) begin n_err++; $display("FAIL rnd_stall_total: got %0d expected %0d", stall_total, exp_stall_total); end
    n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL rnd_mem_err: got %b expected 0", mem_err); end
    tick();
    mem_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 4'h0);
  endtask

  task automatic test_reset_mid_wait();
    logic [75:0] outs;
    drive(1, 1, 0, 1, 1, 3'd6, 16'h0300, 16'h0, 4'b1010);
    mem_ready = 1'b0;
    tick();
    drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 4'h0);
    @(negedge clock);
    n_cmp++; if ({mem_req, stall} !== 2'b11) begin n_err++; $display("FAIL rst_wait_pre: got req=%b stall=%b expected 1/1", mem_req, stall); end
    #2 reset = 1'b0;
    #1;
    outs = {mem_req, mem_we, mem_addr, mem_wdata, stall, data_register_mem, data_for_res_wb,
            rd_wb, reg_write_wb, szcv_flags, mem_err};
    n_cmp++; if (outs !== 76'd0) begin n_err++; $display("FAIL rst_mid_wait: got %h expected 0", outs); end
    tick();
    reset = 1'b1;
    @(negedge clock);
    n_cmp++; if ({mem_req, stall} !== 2'b00) begin n_err++; $display("FAIL rst_abandon: got req=%b stall=%b expected 0/0", mem_req, stall); end
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    drive(1, 0, 0, 1, 0, 3'd7, 16'h7777, 16'h0, 4'h0);
    mem_ready = 1'b0;
    tick();
    drive(1, 1, 0, 1, 0, 3'd4, 16'h0080, 16'h0, 4'h0);
    tick();
    drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 4'h0);
`ifdef MEMORY_P4_TIMEOUT_EN
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (k == 0) begin
        n_cmp++; if (data_for_res_wb !== 16'h7777) begin n_err++; $display("FAIL to_prior_wb: got %h expected 7777", data_for_res_wb); end
      end
      if (!stall) break;
      n++;
      tick();
    end
    n_cmp++; if (n !== 15) begin n_err++; $display("FAIL to_stall_cycles: got %0d expected 15", n); end
    n_cmp++; if ({mem_req, mem_err} !== 2'b10) begin n_err++; $display("FAIL to_complete: got req=%b err=%b expected 1/0", mem_req, mem_err); end
    tick();
    @(negedge clock);
    n_cmp++; if ({data_for_res_wb, rd_wb, reg_write_wb, mem_err, mem_req} !== {16'h0000, 3'd4, 1'b1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL to_wb: got data=%h rd=%0d we=%b err=%b req=%b expected 0000/4/1/1/0", data_for_res_wb, rd_wb, reg_write_wb, mem_err, mem_req);
    end
    tick();
    @(negedge clock);
    n_cmp++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b expected 1", mem_err); end
    tick();
`else
    for (int k = 0; k <= 20; k++) begin
      mem_ready = (k == 20);
      mem_rdata = (k == 20) ? 16'h1357 : 16'hDEAD;
      @(negedge clock);
      if (stall) n++;
      tick();
    end
    mem_ready = 1'b0;
    n_cmp++; if (n !== 20) begin n_err++; $display("FAIL nt_stall_cycles: got %0d expected 20", n); end
    @(negedge clock);
    n_cmp++; if ({data_for_res_wb, rd_wb, reg_write_wb, mem_err} !== {16'h1357, 3'd4, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL nt_wb: got data=%h rd=%0d we=%b err=%b expected 1357/4/1/0", data_for_res_wb, rd_wb, reg_write_wb, mem_err);
    end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load_wait();
    test_store();
    test_back_to_back();
    test_flags();
    test_random();
    test_reset_mid_wait();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_p4.md
# memory_p4

Fourth pipeline stage of the 16-bit processor, directly downstream of the execute stage. Captures the ALU result, flags and forwarded store operand into the EX/MEM register and performs load/store through a ready-handshaked data-memory port. Stalls the pipeline while an access is pending, then drives the MEM/WB register. Also provides the MEM-stage forwarding value consumed by execute.

## Interface
- WIDTH, 16, data/address width
- TIMEOUT_CYCLES, 15, wait limit for an access; used only with MEMORY_P4_TIMEOUT_EN; range 1..255
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute holds a real instruction (0 = bubble)
- op_mem_read / op_mem_write / op_reg_write / op_flag_update  in  1 each  control from execute
- rd_ex  in  3  destination register
- data_register_wire  in  WIDTH  ALU result; also memory address
- ar_ex_forward  in  WIDTH  store data
- cond  in  4  ALU flags (szcv)
- mem_ready  in  1  memory completes the access this cycle
- mem_rdata  in  WIDTH  load data, valid when mem_ready=1
- mem_req / mem_we  out  1 each  access request / write strobe
- mem_addr / mem_wdata  out  WIDTH each  address / store data
- stall  out  1  freeze PC, IF/ID, ID/EX and execute
- data_register_mem  out  WIDTH  MEM-stage forwarding value
- data_for_res_wb  out  WIDTH  writeback data
- rd_wb  out  3;  reg_write_wb  out  1  writeback destination / enable
- szcv_flags  out  4  architectural flag register
- mem_err  out  1  sticky timeout flag

## Operation
- EX/MEM register loads on every edge with stall=0; holds while stall=1. ex_valid=0 loads a bubble (all control bits 0).
- op_mem_write has priority: both read and write set is treated as a store; stores force reg_write to 0.
- szcv_flags <= cond on the edge the EX/MEM register loads a valid instruction with op_flag_update=1.
- FSM is IDLE or ACCESS. When the EX/MEM register loads a valid memory op, the next state is ACCESS. Otherwise the next state is IDLE.
- In ACCESS: mem_req=1, mem_we=store, mem_addr=latched ALU result, mem_wdata=latched store data, and stall=~mem_ready (combinational). If mem_ready=1, the access completes on that edge. The next state is ACCESS if the newly loaded instruction is a memory op (back-to-back), otherwise IDLE.
- In IDLE: mem_req=mem_we=0; address and wdata hold their last values.
- data_register_mem always equals the latched ALU result. It is invalid for loads; the load-use hazard is the decode stage's responsibility.
- MEM/WB register on each edge:
  - MEM valid and stall=0: data_for_res_wb <= load ? mem_rdata : ALU result; rd_wb <= rd; reg_write_wb <= reg_write.
  - Otherwise: reg_write_wb <= 0 and the data holds.

## Timing
- Reset (async, immediate): state IDLE, EX/MEM is a bubble, and every output is 0, including mem_req, stall, szcv_flags and mem_err.
- Reset during ACCESS drops mem_req immediately; the access is abandoned.
- Non-memory op: writeback is visible 1 cycle after leaving execute.
- Memory op with mem_ready on the first ACCESS cycle: no stall; result in WB 1 cycle after leaving execute.
- N wait cycles (mem_ready low): stall is high N cycles; the writeback is delayed N cycles; each stalled cycle injects a WB bubble.
- mem_ready outside ACCESS is ignored.

## Configuration
- MEMORY_P4_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on ACCESS entry or completion and increments each ACCESS cycle with mem_ready=0.
  - When it reaches TIMEOUT_CYCLES, the access is forced complete: a load writes back 16'h0000, mem_err sets (sticky until reset), and stall drops on that cycle.
- Undefined: the block waits indefinitely; mem_err is tied 0; there is no counter logic.

## Structure
- Shared package: FSM state encoding (IDLE, ACCESS), WIDTH default, register-index width (3), flag-index constants (S,Z,C,V), default TIMEOUT_CYCLES.
- One sub-module is natural: memory_p4_timer (wait counter plus compare), instantiated only under MEMORY_P4_TIMEOUT_EN.

## Test plan
- ALU op: rd_ex=3, result 16'h1234, op_reg_write=1 -> next edge data_register_mem=16'h1234; following edge data_for_res_wb=16'h1234, rd_wb=3, reg_write_wb=1, stall never high.
- Load addr 16'h0040, mem_ready low 2 cycles then high with rdata 16'hBEEF -> mem_req high 3 cycles, stall high 2 cycles, then data_for_res_wb=16'hBEEF, reg_write_wb=1.
- Store addr 16'h0010, data 16'h00FF, mem_ready=1 immediately -> mem_req=mem_we=1 for one cycle with that addr/data, reg_write_wb=0, no stall.
- Back-to-back load then store, both ready immediately -> ACCESS held 2 cycles, addresses change on the boundary, no stall, no bubble.
- op_flag_update with cond=4'b0100 -> szcv_flags=4'b0100; a bubble with cond=4'b1111 leaves szcv_flags unchanged.
- Reset asserted mid-wait -> mem_req, stall and all outputs 0 immediately. With MEMORY_P4_TIMEOUT_EN and TIMEOUT_CYCLES=15, a load never ready -> stall drops after 15 cycles, writeback 16'h0000, mem_err=1.
